// File: rtl/ahb_mtx_pkg.sv
// Shared AHB bus-matrix encodings and field widths.
package ahb_mtx_pkg;

  localparam int unsigned TransWidth = 2;
  localparam int unsigned SizeWidth  = 3;
  localparam int unsigned BurstWidth = 3;

  typedef enum logic [1:0] {
    TransIdle   = 2'b00,
    TransBusy   = 2'b01,
    TransNonseq = 2'b10,
    TransSeq    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    BurstSingle = 3'b000,
    BurstIncr   = 3'b001,
    BurstWrap4  = 3'b010,
    BurstIncr4  = 3'b011,
    BurstWrap8  = 3'b100,
    BurstIncr8  = 3'b101,
    BurstWrap16 = 3'b110,
    BurstIncr16 = 3'b111
  } hburst_e;

  typedef enum logic {
    RespOkay  = 1'b0,
    RespError = 1'b1
  } hresp_e;

  // NONSEQ and SEQ request a slot; IDLE and BUSY do not.
  function automatic logic trans_is_active(logic [TransWidth-1:0] trans);
    return trans[1];
  endfunction

endpackage

// File: rtl/ahb_mtx_addr_hold.sv
// Address-phase holding register with pend flag for one matrix input port.
module ahb_mtx_addr_hold
  import ahb_mtx_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned PROT_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load,
  input  logic                  i_release,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [TransWidth-1:0] i_trans,
  input  logic                  i_write,
  input  logic [SizeWidth-1:0]  i_size,
  input  logic [BurstWidth-1:0] i_burst,
  input  logic [PROT_WIDTH-1:0] i_prot,
  input  logic                  i_lock,
  output logic                  o_pend,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [TransWidth-1:0] o_trans,
  output logic                  o_write,
  output logic [SizeWidth-1:0]  o_size,
  output logic [BurstWidth-1:0] o_burst,
  output logic [PROT_WIDTH-1:0] o_prot,
  output logic                  o_lock
);

  logic                  r_pend;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [TransWidth-1:0] r_trans;
  logic                  r_write;
  logic [SizeWidth-1:0]  r_size;
  logic [BurstWidth-1:0] r_burst;
  logic [PROT_WIDTH-1:0] r_prot;
  logic                  r_lock;

  // Load and release are mutually exclusive (load needs pend=0, release needs pend=1).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend  <= 1'b0;
      r_addr  <= '0;
      r_trans <= '0;
      r_write <= 1'b0;
      r_size  <= '0;
      r_burst <= '0;
      r_prot  <= '0;
      r_lock  <= 1'b0;
    end else if (i_load) begin
      r_pend  <= 1'b1;
      r_addr  <= i_addr;
      r_trans <= i_trans;
      r_write <= i_write;
      r_size  <= i_size;
      r_burst <= i_burst;
      r_prot  <= i_prot;
      r_lock  <= i_lock;
    end else if (i_release) begin
      r_pend  <= 1'b0;
    end
  end

  assign o_pend  = r_pend;
  assign o_addr  = r_addr;
  assign o_trans = r_trans;
  assign o_write = r_write;
  assign o_size  = r_size;
  assign o_burst = r_burst;
  assign o_prot  = r_prot;
  assign o_lock  = r_lock;

endmodule

// File: rtl/ahb_mtx_input_stage.sv
// Per-master AHB matrix input stage: holds blocked address phases, muxes held/live
// address toward the matrix and routes ready/response back to the master.
module ahb_mtx_input_stage
  import ahb_mtx_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned PROT_WIDTH = 4
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSELS,
  input  logic [ADDR_WIDTH-1:0] HADDRS,
  input  logic [1:0]            HTRANSS,
  input  logic                  HWRITES,
  input  logic [2:0]            HSIZES,
  input  logic [2:0]            HBURSTS,
  input  logic [PROT_WIDTH-1:0] HPROTS,
  input  logic                  HMASTLOCKS,
  input  logic                  HREADYS,
  output logic                  HREADYOUTS,
  output logic                  HRESPS,
  output logic                  HSELM,
  output logic [ADDR_WIDTH-1:0] HADDRM,
  output logic [1:0]            HTRANSM,
  output logic                  HWRITEM,
  output logic [2:0]            HSIZEM,
  output logic [2:0]            HBURSTM,
  output logic [PROT_WIDTH-1:0] HPROTM,
  output logic                  HMASTLOCKM,
  output logic                  trans_dec,
  input  logic                  active_dec,
  input  logic                  readyout_dec,
  input  logic                  hresp_dec
);

  logic                  w_pend;
  logic [ADDR_WIDTH-1:0] w_h_addr;
  logic [TransWidth-1:0] w_h_trans;
  logic                  w_h_write;
  logic [SizeWidth-1:0]  w_h_size;
  logic [BurstWidth-1:0] w_h_burst;
  logic [PROT_WIDTH-1:0] w_h_prot;
  logic                  w_h_lock;

  logic w_sel_live;
  logic w_live_xfer;
  logic w_launch;
  logic w_load;
  logic w_release;
  logic w_launched;
  logic w_data_phase_d;
  logic r_data_phase;

  assign w_sel_live  = HSELS & HREADYS;
  assign w_live_xfer = w_sel_live & trans_is_active(HTRANSS);
  assign w_launch    = active_dec & readyout_dec;
  assign w_load      = ~w_pend & w_live_xfer & ~w_launch;
  assign w_release   = w_pend & w_launch;
  assign w_launched  = w_release | (~w_pend & w_live_xfer & w_launch);

  ahb_mtx_addr_hold #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .PROT_WIDTH (PROT_WIDTH)
  ) u_addr_hold (
    .i_clk     (HCLK),
    .i_rst_n   (HRESETn),
    .i_load    (w_load),
    .i_release (w_release),
    .i_addr    (HADDRS),
    .i_trans   (HTRANSS),
    .i_write   (HWRITES),
    .i_size    (HSIZES),
    .i_burst   (HBURSTS),
    .i_prot    (HPROTS),
    .i_lock    (HMASTLOCKS),
    .o_pend    (w_pend),
    .o_addr    (w_h_addr),
    .o_trans   (w_h_trans),
    .o_write   (w_h_write),
    .o_size    (w_h_size),
    .o_burst   (w_h_burst),
    .o_prot    (w_h_prot),
    .o_lock    (w_h_lock)
  );

  always_comb begin
    HSELM      = w_sel_live;
    HADDRM     = HADDRS;
    HTRANSM    = w_sel_live ? HTRANSS : TransIdle;
    HWRITEM    = HWRITES;
    HSIZEM     = HSIZES;
    HBURSTM    = HBURSTS;
    HPROTM     = HPROTS;
    HMASTLOCKM = HMASTLOCKS;
    if (w_pend) begin
      HSELM      = 1'b1;
      HADDRM     = w_h_addr;
      HTRANSM    = w_h_trans;
      HWRITEM    = w_h_write;
      HSIZEM     = w_h_size;
      HBURSTM    = w_h_burst;
      HPROTM     = w_h_prot;
      HMASTLOCKM = w_h_lock;
    end
    // BUSY still reaches the arbiter via HSELM/HTRANSM but never raises a request.
    trans_dec = HSELM & trans_is_active(HTRANSM);
  end

  always_comb begin
    w_data_phase_d = r_data_phase;
    if (w_launched) begin
      w_data_phase_d = 1'b1;
    end else if (readyout_dec) begin
      w_data_phase_d = 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_data_phase <= 1'b0;
    end else begin
      r_data_phase <= w_data_phase_d;
    end
  end

  always_comb begin
    HREADYOUTS = 1'b1;
    if (w_pend) begin
      HREADYOUTS = 1'b0;
    end else if (r_data_phase) begin
      HREADYOUTS = readyout_dec;
    end
    HRESPS = r_data_phase ? hresp_dec : RespOkay;
  end

endmodule

// File: tb/tb_ahb_mtx_input_stage.sv
// Randomized scoreboard bench for ahb_mtx_input_stage against a transaction-level model.
module tb_ahb_mtx_input_stage;
  import ahb_mtx_pkg::*;

  localparam int AW = 32;
  localparam int PW = 4;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          HSELS;
  logic [AW-1:0] HADDRS;
  logic [1:0]    HTRANSS;
  logic          HWRITES;
  logic [2:0]    HSIZES;
  logic [2:0]    HBURSTS;
  logic [PW-1:0] HPROTS;
  logic          HMASTLOCKS;
  logic          HREADYS;
  logic          HREADYOUTS;
  logic          HRESPS;
  logic          HSELM;
  logic [AW-1:0] HADDRM;
  logic [1:0]    HTRANSM;
  logic          HWRITEM;
  logic [2:0]    HSIZEM;
  logic [2:0]    HBURSTM;
  logic [PW-1:0] HPROTM;
  logic          HMASTLOCKM;
  logic          trans_dec;
  logic          active_dec;
  logic          readyout_dec;
  logic          hresp_dec;

  ahb_mtx_input_stage #(
    .ADDR_WIDTH (AW),
    .PROT_WIDTH (PW)
  ) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .HSELS        (HSELS),
    .HADDRS       (HADDRS),
    .HTRANSS      (HTRANSS),
    .HWRITES      (HWRITES),
    .HSIZES       (HSIZES),
    .HBURSTS      (HBURSTS),
    .HPROTS       (HPROTS),
    .HMASTLOCKS   (HMASTLOCKS),
    .HREADYS      (HREADYS),
    .HREADYOUTS   (HREADYOUTS),
    .HRESPS       (HRESPS),
    .HSELM        (HSELM),
    .HADDRM       (HADDRM),
    .HTRANSM      (HTRANSM),
    .HWRITEM      (HWRITEM),
    .HSIZEM       (HSIZEM),
    .HBURSTM      (HBURSTM),
    .HPROTM       (HPROTM),
    .HMASTLOCKM   (HMASTLOCKM),
    .trans_dec    (trans_dec),
    .active_dec   (active_dec),
    .readyout_dec (readyout_dec),
    .hresp_dec    (hresp_dec)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [1:0]    trans;
    logic          write;
    logic [2:0]    size;
    logic [2:0]    burst;
    logic [PW-1:0] prot;
    logic          lock;
  } xfer_t;

  typedef struct packed {
    logic  sel;
    xfer_t x;
    logic  tdec;
    logic  rdy;
    logic  resp;
  } obs_t;

  obs_t  exp_q[$];
  xfer_t held[$];   // transfers captured but not yet launched (0 or 1 entries)
  bit    in_dp;     // an address phase has launched and its data phase is outstanding
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;

  xfer_t s_x;
  logic  s_sel, s_act, s_rdy, s_resp;

  function automatic xfer_t live_fields();
    xfer_t x;
    x.addr  = HADDRS;
    x.trans = HTRANSS;
    x.write = HWRITES;
    x.size  = HSIZES;
    x.burst = HBURSTS;
    x.prot  = HPROTS;
    x.lock  = HMASTLOCKS;
    return x;
  endfunction

  function automatic bit is_request(logic [1:0] t);
    return (t == TransNonseq) || (t == TransSeq);
  endfunction

  function automatic logic model_ready(logic ro);
    if (held.size() != 0) return 1'b0;
    if (in_dp) return ro;
    return 1'b1;
  endfunction

  function automatic obs_t model_out();
    obs_t o;
    if (held.size() != 0) begin
      o.sel = 1'b1;
      o.x   = held[0];
    end else begin
      o.sel = HSELS && HREADYS;
      o.x   = live_fields();
      if (!o.sel) o.x.trans = TransIdle;
    end
    o.rdy  = model_ready(readyout_dec);
    o.resp = in_dp ? hresp_dec : 1'b0;
    o.tdec = o.sel && is_request(o.x.trans);
    return o;
  endfunction

  // Advance the model over one clock edge using the inputs present at that edge.
  task automatic model_step();
    bit live, grant, launched;
    live     = HSELS && HREADYS && is_request(HTRANSS);
    grant    = active_dec && readyout_dec;
    launched = 0;
    if (held.size() != 0) begin
      if (grant) begin
        void'(held.pop_front());
        launched = 1;
      end
    end else if (live) begin
      if (grant) launched = 1;
      else held.push_back(live_fields());
    end
    if (launched) in_dp = 1;
    else if (readyout_dec) in_dp = 0;
  endtask

  task automatic do_cycle();
    @(posedge HCLK);
    model_step();
    #1;
    HSELS        = s_sel;
    HADDRS       = s_x.addr;
    HTRANSS      = s_x.trans;
    HWRITES      = s_x.write;
    HSIZES       = s_x.size;
    HBURSTS      = s_x.burst;
    HPROTS       = s_x.prot;
    HMASTLOCKS   = s_x.lock;
    active_dec   = s_act;
    readyout_dec = s_rdy;
    hresp_dec    = s_resp;
    HREADYS      = model_ready(s_rdy);
    #1;
    exp_q.push_back(model_out());
  endtask

  task automatic set_xfer(input logic [AW-1:0] a, input logic [1:0] t, input logic [2:0] b);
    s_sel     = 1'b1;
    s_x.addr  = a;
    s_x.trans = t;
    s_x.write = a[4];
    s_x.size  = 3'd2;
    s_x.burst = b;
    s_x.prot  = 4'h3;
    s_x.lock  = 1'b0;
  endtask

  task automatic set_slave(input logic act, input logic rdy, input logic resp);
    s_act  = act;
    s_rdy  = rdy;
    s_resp = resp;
  endtask

  task automatic randomize_stim();
    s_sel     = ($urandom_range(0, 9) != 0);
    s_x.addr  = $urandom;
    s_x.trans = 2'($urandom_range(0, 3));
    s_x.write = 1'($urandom);
    s_x.size  = 3'($urandom_range(0, 2));
    s_x.burst = 3'($urandom);
    s_x.prot  = 4'($urandom);
    s_x.lock  = ($urandom_range(0, 15) == 0);
    s_act     = ($urandom_range(0, 2) != 0);
    s_rdy     = ($urandom_range(0, 3) != 0);
    s_resp    = ($urandom_range(0, 7) == 0);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs against the next scoreboard entry mid-cycle.
  always @(negedge HCLK) begin
    obs_t e, a;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a.sel  = HSELM;
      a.x    = {HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM, HPROTM, HMASTLOCKM};
      a.tdec = trans_dec;
      a.rdy  = HREADYOUTS;
      a.resp = HRESPS;
      cyc++;
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL scoreboard cyc %0d: got sel=%b x=%h tdec=%b rdy=%b resp=%b expected sel=%b x=%h tdec=%b rdy=%b resp=%b",
                 cyc, a.sel, a.x, a.tdec, a.rdy, a.resp, e.sel, e.x, e.tdec, e.rdy, e.resp);
      end
    end
  end

  initial begin
    HRESETn = 1'b0;
    HSELS = 0; HADDRS = '0; HTRANSS = TransIdle; HWRITES = 0; HSIZES = 0; HBURSTS = 0;
    HPROTS = 0; HMASTLOCKS = 0; HREADYS = 1; active_dec = 0; readyout_dec = 0; hresp_dec = 1;
    s_x = '0; s_sel = 0; s_act = 0; s_rdy = 1; s_resp = 0;
    #12;
    check("reset HREADYOUTS", 64'(HREADYOUTS), 64'd1);
    check("reset HRESPS", 64'(HRESPS), 64'd0);
    check("reset HTRANSM", 64'(HTRANSM), 64'(TransIdle));
    check("reset HSELM", 64'(HSELM), 64'd0);
    check("reset trans_dec", 64'(trans_dec), 64'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    held.delete();
    in_dp = 0;

    // Direct launch.
    set_xfer(32'h2000_0000, TransNonseq, BurstSingle); set_slave(1, 1, 0); do_cycle();
    set_xfer(32'h0, TransIdle, BurstSingle);           set_slave(1, 1, 0); do_cycle();

    // Blocked for 3 cycles, master address wanders, then granted; 2 wait states follow.
    set_xfer(32'h4000_0010, TransNonseq, BurstSingle); set_slave(0, 1, 0); do_cycle();
    set_xfer(32'h5555_0000, TransNonseq, BurstSingle); do_cycle(); do_cycle();
    set_slave(1, 1, 0); do_cycle();
    set_xfer(32'h0, TransIdle, BurstSingle); set_slave(1, 0, 0); do_cycle();
    set_xfer(32'h6666_0004, TransNonseq, BurstSingle); do_cycle();
    set_xfer(32'h0, TransIdle, BurstSingle); set_slave(1, 1, 0); do_cycle();

    // Two-cycle ERROR with IDLE in its second cycle.
    set_xfer(32'h3000_0040, TransNonseq, BurstSingle); set_slave(1, 1, 0); do_cycle();
    set_xfer(32'h0, TransIdle, BurstSingle); set_slave(1, 0, 1); do_cycle();
    set_slave(1, 1, 1); do_cycle();
    set_slave(1, 1, 0); do_cycle();

    // INCR4 burst with a BUSY beat, grant held throughout.
    set_xfer(32'h1000_0000, TransNonseq, BurstIncr4); set_slave(1, 1, 0); do_cycle();
    set_xfer(32'h1000_0004, TransSeq, BurstIncr4);    do_cycle();
    set_xfer(32'h1000_0008, TransBusy, BurstIncr4);   do_cycle();
    set_xfer(32'h1000_0008, TransSeq, BurstIncr4);    do_cycle();
    set_xfer(32'h1000_000C, TransSeq, BurstIncr4);    do_cycle();
    set_xfer(32'h0, TransIdle, BurstSingle);          do_cycle();

    for (int i = 0; i < 2000; i++) begin
      randomize_stim();
      do_cycle();
    end

    // Reset while a transfer is held.
    set_xfer(32'h7000_0020, TransNonseq, BurstSingle); set_slave(0, 1, 0); do_cycle(); do_cycle();
    @(negedge HCLK);
    #1;
    check("pre-reset hold active", 64'(HREADYOUTS), 64'd0);
    HRESETn = 1'b0;
    #1;
    check("mid-hold reset HTRANSM", 64'(HTRANSM), 64'(TransIdle));
    check("mid-hold reset HSELM", 64'(HSELM), 64'd0);
    check("mid-hold reset HREADYOUTS", 64'(HREADYOUTS), 64'd1);
    check("mid-hold reset trans_dec", 64'(trans_dec), 64'd0);
    held.delete();
    in_dp = 0;
    #1;
    HRESETn = 1'b1;

    for (int i = 0; i < 200; i++) begin
      randomize_stim();
      do_cycle();
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge HCLK);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
